// File: rtl/qupls_branch_group_packer.sv
// Repacks sparse 4-slot instruction groups (NOP padding dropped) into dense
// 4-slot output groups. Order is kept, and a branch always closes its group.
// Ports: clk/rst (sync, active-high), flush; in_valid/in_ready with ins_i,
//   vld_i, br_i; out_valid/out_ready with registered ins_o, vld_o, br_o.
// Latency 2 cycles from acceptance to out_valid; in_ready drops when fewer
// than 4 FIFO slots are free; output holds stable while out_ready is low.
module qupls_branch_group_packer #(
  parameter int W      = 64,
  parameter int QDEPTH = 8,
  parameter int TMO    = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           flush,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [4*W-1:0] ins_i,
  input  logic [3:0]     vld_i,
  input  logic [3:0]     br_i,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [4*W-1:0] ins_o,
  output logic [3:0]     vld_o,
  output logic [3:0]     br_o
);
  localparam int AW = $clog2(QDEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]      q_ins [QDEPTH];
  logic [QDEPTH-1:0] q_br;
  logic [AW-1:0]     rd_ptr, wr_ptr;
  logic [CW-1:0]     count, count_next;
  logic [3:0]        idle_cnt;

  logic              accept;
  logic [2:0]        pushed, popped;
  logic [AW-1:0]     wpos [4];
  logic [2:0]        avail, take;
  logic              has_br, ready_emit, load_en, pop;
  logic [4*W-1:0]    g_ins;
  logic [3:0]        g_vld, g_br;

  // A flushed cycle's input is dropped even if the handshake completes.
  assign accept = in_valid & in_ready & ~flush;

  // Live slots are compacted: each one lands at wr_ptr plus the number of
  // live slots below it.
  always_comb begin
    pushed = 3'd0;
    for (int i = 0; i < 4; i++) begin
      wpos[i] = wr_ptr + AW'(pushed);
      if (accept && vld_i[i]) pushed = pushed + 3'd1;
    end
  end

  // Candidate group from the FIFO head; stops right after the first branch.
  always_comb begin
    avail  = (count >= CW'(4)) ? 3'd4 : 3'(count);
    take   = avail;
    has_br = 1'b0;
    g_ins  = '0;
    g_vld  = '0;
    g_br   = '0;
    for (int i = 0; i < 4; i++) begin
      if ((3'(i) < avail) && !has_br) begin
        g_ins[i*W +: W] = q_ins[rd_ptr + AW'(i)];
        g_vld[i]        = 1'b1;
        if (q_br[rd_ptr + AW'(i)]) begin
          g_br[i] = 1'b1;
          has_br  = 1'b1;
          take    = 3'(i + 1);
        end
      end
    end
  end

  assign ready_emit = has_br | (count >= CW'(4)) |
                      ((count != '0) && (idle_cnt == 4'(TMO)));
  assign load_en    = ~out_valid | out_ready;
  assign pop        = load_en & ready_emit;
  assign popped     = pop ? take : 3'd0;
  assign count_next = count + CW'(pushed) - CW'(popped);

  // Payload storage needs no reset; pointers and count define validity.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (accept && vld_i[i]) begin
        q_ins[wpos[i]] <= ins_i[i*W +: W];
        q_br[wpos[i]]  <= br_i[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      idle_cnt  <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      ins_o     <= '0;
      vld_o     <= '0;
      br_o      <= '0;
    end else begin
      wr_ptr   <= wr_ptr + AW'(pushed);
      rd_ptr   <= rd_ptr + AW'(popped);
      count    <= count_next;
      in_ready <= (CW'(QDEPTH) - count_next) >= CW'(4);

      // Idle time only accumulates while a partial group sits untouched.
      if ((pushed != 3'd0) || pop || (count == '0))
        idle_cnt <= '0;
      else if (idle_cnt != 4'(TMO))
        idle_cnt <= idle_cnt + 4'd1;

      if (load_en) begin
        out_valid <= ready_emit;
        ins_o     <= ready_emit ? g_ins : '0;
        vld_o     <= ready_emit ? g_vld : 4'b0000;
        br_o      <= ready_emit ? g_br  : 4'b0000;
      end
    end
  end
endmodule

// File: doc/qupls_branch_group_packer.md
Name: qupls_branch_group_packer

Overview:
- Reverse of the branch-spacing stage: accepts 4-slot instruction groups padded with NOP/empty slots and repacks the live instructions into dense 4-slot output groups.
- Preserves program order and the rule that a branch is always the last live slot of its output group.
- Sits between the branch-spacing output and a downstream stage that prefers full-width groups; it can be bypassed when packing is not wanted.
- Carries an 8-entry compaction FIFO, a registered output group, valid/ready handshakes on both sides, and an idle-timeout flush for partial groups.

Parameters:
- W, 64, payload bits per slot (opaque instruction word/record).
- QDEPTH, 8, compaction FIFO entries; power of two, >= 8.
- TMO, 4, idle cycles before a partial group is emitted; 1..15.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- flush  in  1  pipeline flush (mispredict); discards all held state
- in_valid  in  1  input group present
- in_ready  out  1  input group accepted when in_valid & in_ready
- ins_i  in  4*W  slot payloads, slot 0 = bits W-1:0 (oldest)
- vld_i  in  4  per-slot live flag; 0 = padding NOP, dropped
- br_i  in  4  per-slot branch flag; ignored where vld_i=0
- out_valid  out  1  output group valid
- out_ready  in  1  downstream accepts group when out_valid & out_ready
- ins_o  out  4*W  packed payloads; unused slots = 0
- vld_o  out  4  live slots, always contiguous from slot 0 (0001, 0011, 0111, 1111)
- br_o  out  4  branch flags; at most one bit set, and only in the highest live slot

Behaviour:
- Reset values: in_ready=1, out_valid=0, ins_o=0, vld_o=0, br_o=0; FIFO empty (count=0), idle counter=0. Reset asserted mid-operation discards everything in the same edge; reset has priority over flush.
- in_ready = (QDEPTH - count) >= 4, registered from the post-edge count. Acceptance never depends on popcount(vld_i).
- Push: on an accepted group, the live slots are written in slot order 0..3, skipping vld=0. The FIFO grows by popcount(vld_i) at that edge. A group with vld_i=0000 is accepted and adds nothing.
- Group formation (combinational on the current FIFO head, before this cycle's push):
  - Take k entries, k = min(4, count), truncated just after the first entry with br=1.
  - The group is "ready to emit" when any of: a branch lies within the first min(4,count) entries; count >= 4; or count > 0 and the idle counter = TMO.
- Output register load: at an edge where (!out_valid | out_ready) and a group is ready to emit:
  - Pop k entries and load ins_o/vld_o/br_o; set out_valid=1.
  - If no group is ready and (!out_valid | out_ready), set out_valid=0 and ins_o/vld_o/br_o=0.
  - While out_valid & !out_ready, the outputs hold bit-stable.
- Simultaneous push and pop in one edge is legal: count_next = count + pushed - popped.
- Latency: a group accepted at edge N is in the FIFO after N. If it completes an emit condition, out_valid rises after edge N+1 (2 cycles).
- Idle counter:
  - Clears on any push of >= 1 live entry, on any pop, and when count = 0.
  - Otherwise increments, saturating at TMO.
  - Timeout emission therefore occurs TMO+1 edges after the last live push with no full group present.
- Flush: at the edge it is sampled, empty the FIFO, clear the idle counter, out_valid=0, outputs=0. Any same-cycle input group is discarded, even if in_valid & in_ready.
- Pointers are wrap-around mod QDEPTH. Count width is clog2(QDEPTH)+1. Overflow is impossible by the in_ready rule; a bench assertion must check count <= QDEPTH.

Test Plan:
- Dense pass-through: one group, vld_i=1111, br_i=0000, out_ready=1 -> after 2 edges, out_valid=1, vld_o=1111, br_o=0000, ins_o equals ins_i.
- Repack: groups {A, B, pad, pad} then {pad, pad, C, D}, all br=0, back-to-back -> one output group A,B,C,D with vld_o=1111. Exactly one out_valid pulse.
- Branch terminates: groups {A, Bbr, pad, pad} then {C, D, E, pad} -> outputs {A,B} (vld_o=0011, br_o=0010), then {C,D,E} after timeout (vld_o=0111, br_o=0000). Check the idle counter reaches TMO=4 before the second emit.
- Backpressure: out_ready=0 with 3 full groups offered -> first group held stable; FIFO reaches 8; in_ready=0. Release out_ready -> groups drain in order; no loss, no duplication.
- Flush mid-stream: FIFO count=5, out_valid=1, flush=1 together with in_valid=1 -> next cycle out_valid=0, count=0, in_ready=1. The flushed-cycle input never appears on the output.
- Reset mid-operation: rst=1 while out_valid=1 and count=6 -> next cycle all outputs at their reset values. The first post-reset group emits normally 2 cycles after acceptance.
